// File: rtl/mem_responder_if.sv
// Request/response and RAM-side bundle for the memory responder.
// The responder connects through the slave modport; the datapath and the
// RAM model (or a bench standing in for both) use the master modport.
interface mem_responder_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
);

  // datapath request side
  logic              halt;
  logic              imemREN;
  logic [ADDR_W-1:0] imemaddr;
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [DATA_W-1:0] dmemstore;

  // datapath response side
  logic              ihit;
  logic [DATA_W-1:0] imemload;
  logic              dhit;
  logic [DATA_W-1:0] dmemload;
  logic              flushed;

  // single-port RAM side
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ramready;

  // service counters
  logic [CNT_W-1:0]  icount;
  logic [CNT_W-1:0]  dcount;

  modport slave (
    input  halt, imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    output ihit, imemload, dhit, dmemload, flushed,
    output ramREN, ramWEN, ramaddr, ramstore,
    input  ramload, ramready,
    output icount, dcount
  );

  modport master (
    output halt, imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  ihit, imemload, dhit, dmemload, flushed,
    input  ramREN, ramWEN, ramaddr, ramstore,
    output ramload, ramready,
    input  icount, dcount
  );

endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: arbitrates instruction fetches and data accesses
// onto one single-port RAM, returns one-cycle hit pulses with load data,
// counts serviced requests and latches a sticky flushed flag on halt.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | no access in flight; arbitrate halt > data > fetch
// DACC   | data read/write on the RAM, strobes held until ramready
// IACC   | instruction fetch on the RAM, ramREN held until ramready
// RESP   | one-cycle hit pulse, counter bump, bubble before re-arbitration
// HALTED | flushed asserted, all requests ignored until reset
module mem_responder #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic CLK,
  input  logic RST,
  mem_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DACC   = 3'd1,
    IACC   = 3'd2,
    RESP   = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              data_req;
  logic              ihit_q;
  logic              dhit_q;
  logic [DATA_W-1:0] imemload_q;
  logic [DATA_W-1:0] dmemload_q;
  logic              flushed_q;
  logic              ram_ren_q;
  logic              ram_wen_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_store_q;
  logic [CNT_W-1:0]  icount_q;
  logic [CNT_W-1:0]  dcount_q;

  assign data_req = bus.dmemREN | bus.dmemWEN;

  // State register; reset abandons any in-flight access.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state arbitration: halt wins, then data, then fetch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.halt) begin
          state_d = HALTED;
        end else if (data_req) begin
          state_d = DACC;
        end else if (bus.imemREN) begin
          state_d = IACC;
        end
      end
      DACC, IACC: begin
        if (bus.ramready) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      HALTED:  state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winning request into the registered RAM strobes/address/data.
  // Strobes stay up until ramready, so a dropped request still completes.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ram_ren_q   <= 1'b0;
      ram_wen_q   <= 1'b0;
      ram_addr_q  <= '0;
      ram_store_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (!bus.halt && data_req) begin
            // write flag is dmemWEN alone, so WEN wins over REN
            ram_ren_q   <= ~bus.dmemWEN;
            ram_wen_q   <= bus.dmemWEN;
            ram_addr_q  <= {bus.dmemaddr[ADDR_W-1:2], 2'b00};
            ram_store_q <= bus.dmemstore;
          end else if (!bus.halt && bus.imemREN) begin
            ram_ren_q   <= 1'b1;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= {bus.imemaddr[ADDR_W-1:2], 2'b00};
          end
        end
        DACC, IACC: begin
          if (bus.ramready) begin
            ram_ren_q <= 1'b0;
            ram_wen_q <= 1'b0;
          end
        end
        default: begin
          ram_ren_q <= 1'b0;
          ram_wen_q <= 1'b0;
        end
      endcase
    end
  end

  // Capture RAM data on completion and raise the matching hit for RESP.
  // Load registers keep their value afterwards; only meaningful with the hit.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      imemload_q <= '0;
      dmemload_q <= '0;
    end else begin
      ihit_q <= 1'b0;
      dhit_q <= 1'b0;
      if (state_q == DACC && bus.ramready) begin
        dhit_q     <= 1'b1;
        dmemload_q <= bus.ramload;
      end
      if (state_q == IACC && bus.ramready) begin
        ihit_q     <= 1'b1;
        imemload_q <= bus.ramload;
      end
    end
  end

  // Service counters bump on the edge that leaves RESP; they wrap freely.
  always_ff @(posedge CLK) begin
    if (RST) begin
      icount_q <= '0;
      dcount_q <= '0;
    end else if (state_q == RESP) begin
      if (ihit_q) begin
        icount_q <= icount_q + CNT_W'(1);
      end
      if (dhit_q) begin
        dcount_q <= dcount_q + CNT_W'(1);
      end
    end
  end

  // Sticky halt acknowledge, raised on entry to HALTED.
  always_ff @(posedge CLK) begin
    if (RST) begin
      flushed_q <= 1'b0;
    end else if (state_d == HALTED) begin
      flushed_q <= 1'b1;
    end
  end

  assign bus.ihit     = ihit_q;
  assign bus.imemload = imemload_q;
  assign bus.dhit     = dhit_q;
  assign bus.dmemload = dmemload_q;
  assign bus.flushed  = flushed_q;
  assign bus.ramREN   = ram_ren_q;
  assign bus.ramWEN   = ram_wen_q;
  assign bus.ramaddr  = ram_addr_q;
  assign bus.ramstore = ram_store_q;
  assign bus.icount   = icount_q;
  assign bus.dcount   = dcount_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a table of single transactions plus
// hand-written sequences for arbitration, reset abort, counter wrap, halt.
module tb_mem_responder;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 4;

  logic clk;
  logic rst;

  mem_responder_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_ihit = 0;

  logic [CW-1:0] exp_ic = '0;
  logic [CW-1:0] exp_dc = '0;

  always @(negedge clk) if (bus.ihit === 1'b1) n_ihit++;

  typedef struct {
    logic        ireq;
    logic        dren;
    logic        dwen;
    logic [31:0] iaddr;
    logic [31:0] daddr;
    logic [31:0] store;
    logic [31:0] load;
    int          delay;
    logic        e_ren;
    logic        e_wen;
    logic [31:0] e_addr;
    logic        e_ihit;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " ihit"},   32'(bus.ihit),   32'd0);
    chk({tag, " dhit"},   32'(bus.dhit),   32'd0);
    chk({tag, " ramREN"}, 32'(bus.ramREN), 32'd0);
    chk({tag, " ramWEN"}, 32'(bus.ramWEN), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk_idle_outputs(tag);
    chk({tag, " imemload"}, bus.imemload,       32'd0);
    chk({tag, " dmemload"}, bus.dmemload,       32'd0);
    chk({tag, " flushed"},  32'(bus.flushed),   32'd0);
    chk({tag, " ramaddr"},  bus.ramaddr,        32'd0);
    chk({tag, " ramstore"}, bus.ramstore,       32'd0);
    chk({tag, " icount"},   32'(bus.icount),    32'd0);
    chk({tag, " dcount"},   32'(bus.dcount),    32'd0);
  endtask

  // One complete transaction starting and ending at a negedge in IDLE.
  task automatic do_txn(input vec_t v, input string tag);
    bus.imemREN   = v.ireq;
    bus.imemaddr  = v.iaddr;
    bus.dmemREN   = v.dren;
    bus.dmemWEN   = v.dwen;
    bus.dmemaddr  = v.daddr;
    bus.dmemstore = v.store;
    @(negedge clk);
    for (int k = 0; k <= v.delay; k++) begin
      chk({tag, " ramREN"},  32'(bus.ramREN), 32'(v.e_ren));
      chk({tag, " ramWEN"},  32'(bus.ramWEN), 32'(v.e_wen));
      chk({tag, " ramaddr"}, bus.ramaddr,     v.e_addr);
      if (v.e_wen) chk({tag, " ramstore"}, bus.ramstore, v.store);
      chk({tag, " early hit"}, 32'(bus.ihit | bus.dhit), 32'd0);
      if (k < v.delay) @(negedge clk);
    end
    bus.ramready = 1'b1;
    bus.ramload  = v.load;
    bus.imemREN  = 1'b0;
    bus.dmemREN  = 1'b0;
    bus.dmemWEN  = 1'b0;
    @(negedge clk);
    bus.ramready = 1'b0;
    chk({tag, " ihit"}, 32'(bus.ihit), 32'(v.e_ihit));
    chk({tag, " dhit"}, 32'(bus.dhit), 32'(!v.e_ihit));
    if (v.e_ihit) chk({tag, " imemload"}, bus.imemload, v.load);
    else          chk({tag, " dmemload"}, bus.dmemload, v.load);
    chk({tag, " resp strobes"}, 32'(bus.ramREN | bus.ramWEN), 32'd0);
    if (v.e_ihit) exp_ic = exp_ic + 1'b1;
    else          exp_dc = exp_dc + 1'b1;
    @(negedge clk);
    chk({tag, " hit width"}, 32'(bus.ihit | bus.dhit), 32'd0);
    chk({tag, " icount"}, 32'(bus.icount), 32'(exp_ic));
    chk({tag, " dcount"}, 32'(bus.dcount), 32'(exp_dc));
  endtask

  vec_t vecs[5];
  vec_t fv;
  int   ihit_base;

  initial begin
    // fetch 0x40, ready on first cycle
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 32'h2402_0001, 0,
                1'b1, 1'b0, 32'h0000_0040, 1'b1};
    // data read, two wait cycles
    vecs[1] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0104, 32'h0, 32'h1234_5678, 2,
                1'b1, 1'b0, 32'h0000_0104, 1'b0};
    // REN and WEN together: write wins, low address bits cleared
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0207, 32'hDEAD_BEEF, 32'h0000_0000, 0,
                1'b0, 1'b1, 32'h0000_0204, 1'b0};
    // fetch from top of address space, one wait cycle
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'hA5A5_5A5A, 1,
                1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1};
    // write only, three wait cycles
    vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_1003, 32'h0BAD_F00D, 32'hFFFF_0000, 3,
                1'b0, 1'b1, 32'h0000_1000, 1'b0};

    rst = 1'b1;
    bus.halt = 1'b0;
    bus.imemREN = 1'b0;
    bus.imemaddr = '0;
    bus.dmemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    bus.dmemaddr = '0;
    bus.dmemstore = '0;
    bus.ramload = '0;
    bus.ramready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // simultaneous fetch and data read: data first, then fetch
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0080;
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h0000_0100;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk("both ramREN held", 32'(bus.ramREN), 32'd1);
      chk("both data addr", bus.ramaddr, 32'h0000_0100);
      if (k < 3) @(negedge clk);
    end
    bus.ramready = 1'b1;
    bus.ramload  = 32'h1111_2222;
    bus.dmemREN  = 1'b0;
    @(negedge clk);
    bus.ramready = 1'b0;
    chk("both dhit", 32'(bus.dhit), 32'd1);
    chk("both no ihit yet", 32'(bus.ihit), 32'd0);
    chk("both dmemload", bus.dmemload, 32'h1111_2222);
    exp_dc = exp_dc + 1'b1;
    @(negedge clk);
    chk("both dcount", 32'(bus.dcount), 32'(exp_dc));
    @(negedge clk);
    chk("both fetch ramREN", 32'(bus.ramREN), 32'd1);
    chk("both fetch addr", bus.ramaddr, 32'h0000_0080);
    bus.ramready = 1'b1;
    bus.ramload  = 32'h3333_4444;
    bus.imemREN  = 1'b0;
    @(negedge clk);
    bus.ramready = 1'b0;
    chk("both ihit", 32'(bus.ihit), 32'd1);
    chk("both imemload", bus.imemload, 32'h3333_4444);
    exp_ic = exp_ic + 1'b1;
    @(negedge clk);
    chk("both icount", 32'(bus.icount), 32'(exp_ic));

    // reset in the middle of a data access with ramready low
    bus.dmemREN  = 1'b1;
    bus.dmemaddr = 32'h0000_0300;
    @(negedge clk);
    chk("rstmid in DACC", 32'(bus.ramREN), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("rstmid");
    rst = 1'b0;
    bus.dmemREN  = 1'b0;
    bus.ramready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_idle_outputs($sformatf("rstmid after%0d", k));
    end
    bus.ramready = 1'b0;
    exp_ic = '0;
    exp_dc = '0;
    @(negedge clk);

    // 17 fetches wrap the 4-bit fetch counter to 1
    ihit_base = n_ihit;
    for (int i = 0; i < 17; i++) begin
      fv = '{1'b1, 1'b0, 1'b0, 32'(i * 4), 32'h0, 32'h0, 32'hC000_0000 + 32'(i), i % 2,
             1'b1, 1'b0, 32'(i * 4), 1'b1};
      do_txn(fv, $sformatf("wrap%0d", i));
    end
    chk("wrap icount", 32'(bus.icount), 32'd1);
    chk("wrap ihit total", 32'(n_ihit - ihit_base), 32'd17);

    // halt while a fetch is in flight
    bus.imemREN  = 1'b1;
    bus.imemaddr = 32'h0000_0044;
    @(negedge clk);
    chk("halt IACC ramREN", 32'(bus.ramREN), 32'd1);
    bus.halt     = 1'b1;
    bus.ramready = 1'b1;
    bus.ramload  = 32'h5555_AAAA;
    @(negedge clk);
    bus.ramready = 1'b0;
    chk("halt ihit", 32'(bus.ihit), 32'd1);
    chk("halt imemload", bus.imemload, 32'h5555_AAAA);
    chk("halt not yet flushed", 32'(bus.flushed), 32'd0);
    @(negedge clk);
    chk("halt icount", 32'(bus.icount), 32'd2);
    @(negedge clk);
    bus.halt = 1'b0;
    bus.dmemWEN = 1'b1;
    for (int k = 0; k < 12; k++) begin
      chk($sformatf("halted flushed%0d", k), 32'(bus.flushed), 32'd1);
      chk_idle_outputs($sformatf("halted%0d", k));
      @(negedge clk);
    end
    chk("halted icount frozen", 32'(bus.icount), 32'd2);
    chk("halted dcount frozen", 32'(bus.dcount), 32'd0);
    bus.imemREN = 1'b0;
    bus.dmemWEN = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("halt cleared by reset", 32'(bus.flushed), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the datapath's instruction and data request interface.
- Accepts instruction fetch requests and data read/write requests, arbitrates them onto one single-port RAM with a ready handshake, and returns ihit/dhit pulses with load data.
- Sits between the datapath request port and the RAM model or bus.
- Keeps serviced-request counters for performance checks, and latches a sticky flushed flag on halt.

Parameters:
- ADDR_W, 32, request/RAM address width
- DATA_W, 32, data word width
- CNT_W, 32, width of the service counters

Ports:
- CLK  in  1  clock, all state updates on rising edge
- RST  in  1  synchronous, active-high reset
- halt  in  1  datapath halt request
- imemREN  in  1  instruction fetch request
- imemaddr  in  ADDR_W  fetch address
- dmemREN  in  1  data read request
- dmemWEN  in  1  data write request
- dmemaddr  in  ADDR_W  data address
- dmemstore  in  DATA_W  write data
- ihit  out  1  one-cycle pulse, fetch complete
- imemload  out  DATA_W  fetched word, valid while ihit=1
- dhit  out  1  one-cycle pulse, data access complete
- dmemload  out  DATA_W  read word, valid while dhit=1
- flushed  out  1  sticky halt acknowledge
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  ADDR_W  RAM word address, bits [1:0] forced to 0
- ramstore  out  DATA_W  RAM write data
- ramload  in  DATA_W  RAM read data
- ramready  in  1  RAM access complete this cycle
- icount  out  CNT_W  serviced fetches
- dcount  out  CNT_W  serviced data accesses

Behaviour:
- Reset (RST=1 at edge):
  - State goes to IDLE.
  - All outputs go to 0: hits, loads, flushed, RAM strobes, ramaddr, ramstore, counters.
  - Reset aborts any in-flight access. RAM strobes drop the cycle after the reset edge and no hit is issued.
- FSM states: IDLE, DACC, IACC, RESP, HALTED.
- IDLE:
  - halt=1 -> HALTED. Halt has priority over new requests.
  - Else (dmemREN|dmemWEN)=1 -> DACC. Latch dmemaddr, dmemstore, and the write flag; the write flag is dmemWEN, so WEN wins if both REN and WEN are set.
  - Else imemREN=1 -> IACC. Latch imemaddr.
  - Else stay in IDLE.
  - Data always has priority over fetch.
- DACC / IACC:
  - Drive ramaddr from the latched address with bits [1:0]=0.
  - DACC drives ramREN = !write and ramWEN = write, with ramstore from the latch. IACC drives ramREN=1.
  - Strobes are registered and held stable until ramready.
  - On ramready=1: capture ramload into dmemload or imemload, go to RESP, and register the hit so it is high in RESP.
  - Waits are unbounded; there is no timeout.
- RESP:
  - Exactly one of ihit/dhit is high for exactly this one cycle. The matching load register is valid.
  - RAM strobes are 0.
  - The matching counter increments by 1 at the end of RESP and wraps modulo 2^CNT_W.
  - Then -> IDLE unconditionally. RESP is a guaranteed one-cycle bubble so the requester can retire or update its request before re-arbitration.
- HALTED:
  - flushed=1, held until reset. No RAM strobes, no hits; all requests are ignored.
- Request drop: a request deasserted while in DACC/IACC does not cancel the access. It completes and hits normally.
- Load registers hold their value after the hit; only the latched data is meaningful while the hit is high.
- Latency: from IDLE with a request and a RAM that is ready on the first access cycle, the hit appears 2 cycles after the request is sampled (IDLE -> ACC -> RESP).
- Throughput: at most one access per 3 cycles.

Test Plan:
- Reset, then imemREN=1, imemaddr=0x0000_0040, ramready=1 on the first IACC cycle, ramload=0x2402_0001:
  - ramREN=1 and ramaddr=0x40 for 1 cycle.
  - Next cycle ihit=1 and imemload=0x24020001 for one cycle.
  - icount=1.
- imemREN=1 and dmemREN=1 together, dmemaddr=0x100, ramready delayed 3 cycles:
  - Data is served first; ramREN is held 4 cycles; dhit pulses, then ihit follows.
  - dcount=1 and icount=1.
- dmemWEN=1 and dmemREN=1, dmemaddr=0x0000_0207, dmemstore=0xDEAD_BEEF:
  - ramWEN=1, ramREN=0, ramaddr=0x204, ramstore=0xDEADBEEF; dhit pulses once.
- halt=1 while an IACC access is in flight:
  - The fetch completes and ihit pulses.
  - Then HALTED, flushed=1, held for 10+ cycles despite imemREN=1; no further strobes.
- RST=1 in the middle of a DACC with ramready=0:
  - Next cycle all outputs are 0, no dhit ever occurs, state is IDLE, counters are 0.
- With CNT_W=4, perform 17 fetches:
  - icount wraps to 1; ihit count equals 17.
